// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared state encoding, instruction-word bit positions and the
//               idle instruction word for the core instruction sequencer.
// Revision    : 1.0  initial release
// ============================================================================
package core_pkg;

    localparam int c_ADDR_W     = 11;
    localparam int c_INST_W     = 34;

    localparam int c_ACC        = 33;
    localparam int c_CEN_PMEM   = 32;
    localparam int c_WEN_PMEM   = 31;
    localparam int c_A_PMEM_LSB = 20;
    localparam int c_CEN_XMEM   = 19;
    localparam int c_WEN_XMEM   = 18;
    localparam int c_A_XMEM_LSB = 7;
    localparam int c_OFIFO_RD   = 6;
    localparam int c_IFIFO_WR   = 5;
    localparam int c_IFIFO_RD   = 4;
    localparam int c_L0_RD      = 3;
    localparam int c_L0_WR      = 2;
    localparam int c_EXECUTE    = 1;
    localparam int c_LOAD       = 0;

    // Both memories deselected with write disabled; everything else zero.
    localparam logic [c_INST_W-1:0] IDLE_INST =
        (c_INST_W'(1) << c_CEN_PMEM) | (c_INST_W'(1) << c_WEN_PMEM) |
        (c_INST_W'(1) << c_CEN_XMEM) | (c_INST_W'(1) << c_WEN_XMEM);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WLD_L0   = 3'd1,
        S_WLD_ARR  = 3'd2,
        S_WLD_WAIT = 3'd3,
        S_XLD_L0   = 3'd4,
        S_EXEC     = 3'd5,
        S_DRAIN    = 3'd6,
        S_DONE     = 3'd7
    } state_t;

endpackage
`default_nettype wire

// File: rtl/inst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : inst_sequencer
// Description : Walks one layer pass (weight load, activation load, execute,
//               psum drain) and emits the registered core instruction word.
// Revision    : 1.0  initial release
// ============================================================================
module inst_sequencer
    import core_pkg::*;
#(
    parameter int row = 8,
    parameter int col = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [c_ADDR_W-1:0]   w_base,
    input  logic [c_ADDR_W-1:0]   x_base,
    input  logic [c_ADDR_W-1:0]   p_base,
    input  logic [c_ADDR_W-1:0]   num_x,
    input  logic                  acc_en,
    input  logic                  ofifo_valid,
    output logic [c_INST_W-1:0]   inst,
    output logic                  busy,
    output logic                  done
);

    localparam logic [c_ADDR_W-1:0] c_ROW_LAST  = c_ADDR_W'(row - 1);
    localparam logic [c_ADDR_W-1:0] c_COL_LAST  = c_ADDR_W'(col - 1);
    localparam logic [c_ADDR_W-1:0] c_WAIT_LAST = c_ADDR_W'(row + col - 1);

    state_t                r_state;
    logic [c_ADDR_W-1:0]   r_cnt;
    logic [c_ADDR_W-1:0]   r_reads;
    logic [c_ADDR_W-1:0]   r_w_base;
    logic [c_ADDR_W-1:0]   r_x_base;
    logic [c_ADDR_W-1:0]   r_p_base;
    logic [c_ADDR_W-1:0]   r_num_x;
    logic                  r_acc_en;
    logic [c_INST_W-1:0]   r_inst;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_ofifo_rd;
    logic [c_ADDR_W-1:0]   w_reads_next;

    // The only combinational output; it must stay low throughout reset.
    assign w_ofifo_rd   = ~reset & (r_state == S_DRAIN) & ofifo_valid &
                          (r_reads < r_num_x);
    assign w_reads_next = r_reads + {{(c_ADDR_W-1){1'b0}}, w_ofifo_rd};

    assign inst = r_inst | (c_INST_W'(w_ofifo_rd) << c_OFIFO_RD);
    assign busy = r_busy;
    assign done = r_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_reads  <= '0;
            r_w_base <= '0;
            r_x_base <= '0;
            r_p_base <= '0;
            r_num_x  <= '0;
            r_acc_en <= 1'b0;
            r_inst   <= IDLE_INST;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_inst            <= IDLE_INST;
            r_inst[c_L0_WR]   <= ~r_inst[c_CEN_XMEM];
            r_done            <= 1'b0;
            r_reads           <= w_reads_next;

            // Psum write lands one cycle after its OFIFO read, in any state.
            if (w_ofifo_rd) begin
                r_inst[c_CEN_PMEM]                      <= 1'b0;
                r_inst[c_WEN_PMEM]                      <= 1'b0;
                r_inst[c_A_PMEM_LSB +: c_ADDR_W]        <= r_p_base + r_reads;
                r_inst[c_ACC]                           <= r_acc_en;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_w_base                         <= w_base;
                        r_x_base                         <= x_base;
                        r_p_base                         <= p_base;
                        r_num_x                          <= num_x;
                        r_acc_en                         <= acc_en;
                        r_reads                          <= '0;
                        r_cnt                            <= '0;
                        r_busy                           <= 1'b1;
                        r_state                          <= S_WLD_L0;
                        r_inst[c_CEN_XMEM]               <= 1'b0;
                        r_inst[c_A_XMEM_LSB +: c_ADDR_W] <= w_base;
                    end
                end
                S_WLD_L0: begin
                    if (r_cnt == c_ROW_LAST) begin
                        r_cnt             <= '0;
                        r_state           <= S_WLD_ARR;
                        r_inst[c_L0_RD]   <= 1'b1;
                        r_inst[c_LOAD]    <= 1'b1;
                    end else begin
                        r_cnt                            <= r_cnt + 1'b1;
                        r_inst[c_CEN_XMEM]               <= 1'b0;
                        r_inst[c_A_XMEM_LSB +: c_ADDR_W] <= r_w_base + r_cnt + 1'b1;
                    end
                end
                S_WLD_ARR: begin
                    if (r_cnt == c_COL_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_WLD_WAIT;
                    end else begin
                        r_cnt           <= r_cnt + 1'b1;
                        r_inst[c_L0_RD] <= 1'b1;
                        r_inst[c_LOAD]  <= 1'b1;
                    end
                end
                S_WLD_WAIT: begin
                    if (r_cnt == c_WAIT_LAST) begin
                        r_cnt <= '0;
                        if (r_num_x == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state                          <= S_XLD_L0;
                            r_inst[c_CEN_XMEM]               <= 1'b0;
                            r_inst[c_A_XMEM_LSB +: c_ADDR_W] <= r_x_base;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_XLD_L0: begin
                    if (r_cnt == r_num_x - 1'b1) begin
                        r_cnt             <= '0;
                        r_state           <= S_EXEC;
                        r_inst[c_L0_RD]   <= 1'b1;
                        r_inst[c_EXECUTE] <= 1'b1;
                    end else begin
                        r_cnt                            <= r_cnt + 1'b1;
                        r_inst[c_CEN_XMEM]               <= 1'b0;
                        r_inst[c_A_XMEM_LSB +: c_ADDR_W] <= r_x_base + r_cnt + 1'b1;
                    end
                end
                S_EXEC: begin
                    if (r_cnt == r_num_x - 1'b1) begin
                        r_cnt   <= '0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_cnt             <= r_cnt + 1'b1;
                        r_inst[c_L0_RD]   <= 1'b1;
                        r_inst[c_EXECUTE] <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (w_reads_next == r_num_x) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_sequencer
// Description : Randomized bench comparing the instruction stream against a
//               phase-timeline reference model of one layer pass.
// Revision    : 1.0  initial release
// ============================================================================
module tb_inst_sequencer;

    localparam int ROW = 8;
    localparam int COL = 8;
    localparam int T0  = 2 * ROW + 2 * COL;
    localparam logic [33:0] c_IDLE_E = 34'h1_800C_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [10:0] w_base, x_base, p_base, num_x;
    logic        acc_en;
    logic        ofifo_valid;
    logic [33:0] inst;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    inst_sequencer #(.row(ROW), .col(COL)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .w_base      (w_base),
        .x_base      (x_base),
        .p_base      (p_base),
        .num_x       (num_x),
        .acc_en      (acc_en),
        .ofifo_valid (ofifo_valid),
        .inst        (inst),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // vmode: 0 random valid, 1 valid always high, 2 fixed 1,0,0,1,1,0,1 pattern in DRAIN.
    // abort_t > 0 asserts reset during that cycle of the pass.
    task automatic run_pass(input logic [10:0] wb, input logic [10:0] xb,
                            input logic [10:0] pb, input logic [10:0] n,
                            input logic acc, input int vmode, input int abort_t);
        bit          pattern [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int          t = 1;
        int          k = 0;
        int          drain_i = 0;
        int          done_t = (n == 0) ? T0 + 1 : -1;
        bit          prev_read = 1'b0;
        bit          cur_read;
        bit          pend_wr = 1'b0;
        logic [10:0] pend_addr = '0;
        bit          in_drain;
        logic [33:0] exp;
        logic        exp_done;

        w_base = wb; x_base = xb; p_base = pb; num_x = n; acc_en = acc;
        ofifo_valid = 1'($urandom);
        start = 1'b1;
        @(posedge clk);
        while (1) begin
            #1;
            in_drain = (n != 0) && (t > T0 + 2 * int'(n)) && (done_t < 0);
            start  = (t == done_t) ? 1'b1 : 1'($urandom);
            w_base = 11'($urandom); x_base = 11'($urandom);
            p_base = 11'($urandom); num_x  = 11'($urandom);
            acc_en = 1'($urandom);
            case (vmode)
                1:       ofifo_valid = 1'b1;
                2:       ofifo_valid = in_drain ? pattern[drain_i % 7] : 1'($urandom);
                default: ofifo_valid = 1'($urandom);
            endcase
            if (in_drain) drain_i++;
            if (t == abort_t) begin
                reset = 1'b1;
                ofifo_valid = 1'b1;
                #1;
                chk($sformatf("rst_ofifo_rd t=%0d", t), 64'(inst[6]), 64'd0);
                @(posedge clk);
                #1;
                reset = 1'b0;
                start = 1'b0;
                #1;
                chk("post_rst_inst", 64'(inst), 64'(c_IDLE_E));
                chk("post_rst_busy", 64'(busy), 64'd0);
                chk("post_rst_done", 64'(done), 64'd0);
                return;
            end
            #1;
            exp = c_IDLE_E;
            if (prev_read) exp[2] = 1'b1;
            if (pend_wr) begin
                exp[33]    = acc;
                exp[32]    = 1'b0;
                exp[31]    = 1'b0;
                exp[30:20] = pend_addr;
                pend_wr    = 1'b0;
            end
            cur_read = 1'b0;
            exp_done = 1'b0;
            if (t == done_t) begin
                exp_done = 1'b1;
            end else if (t <= ROW) begin
                exp[19]   = 1'b0;
                exp[17:7] = wb + 11'(t - 1);
                cur_read  = 1'b1;
            end else if (t <= ROW + COL) begin
                exp[3] = 1'b1;
                exp[0] = 1'b1;
            end else if (t <= T0) begin
                exp = exp;
            end else if (t <= T0 + int'(n)) begin
                exp[19]   = 1'b0;
                exp[17:7] = xb + 11'(t - T0 - 1);
                cur_read  = 1'b1;
            end else if (t <= T0 + 2 * int'(n)) begin
                exp[3] = 1'b1;
                exp[1] = 1'b1;
            end else if (ofifo_valid && k < int'(n)) begin
                exp[6]    = 1'b1;
                pend_wr   = 1'b1;
                pend_addr = pb + 11'(k);
                k++;
                if (k == int'(n)) done_t = t + 1;
            end
            prev_read = cur_read;
            chk($sformatf("inst t=%0d", t), 64'(inst), 64'(exp));
            chk($sformatf("busy t=%0d", t), 64'(busy), 64'd1);
            chk($sformatf("done t=%0d", t), 64'(done), 64'(exp_done));
            if (t == done_t) break;
            if (t > 4000) begin
                chk("pass_timeout", 64'd1, 64'd0);
                return;
            end
            @(posedge clk);
            t++;
        end
        // Cycle after DONE: back in IDLE even though start was high in DONE.
        @(posedge clk);
        #1;
        start = 1'b0;
        #1;
        chk("after_done_inst", 64'(inst), 64'(c_IDLE_E));
        chk("after_done_busy", 64'(busy), 64'd0);
        chk("after_done_done", 64'(done), 64'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; ofifo_valid = 1'b0; acc_en = 1'b0;
        w_base = '0; x_base = '0; p_base = '0; num_x = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_inst", 64'(inst), 64'(c_IDLE_E));
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #2;

        run_pass(11'h010, 11'h100, 11'h200, 11'd4, 1'b0, 1, 0);
        run_pass(11'h040, 11'h120, 11'h300, 11'd4, 1'b0, 2, 0);
        run_pass(11'h7FC, 11'h7FE, 11'h7FE, 11'd4, 1'b1, 0, 0);
        run_pass(11'h123, 11'h456, 11'h789, 11'd0, 1'b1, 0, 0);
        run_pass(11'h010, 11'h100, 11'h200, 11'd6, 1'b0, 1, T0 + 6 + 2);
        run_pass(11'h010, 11'h100, 11'h200, 11'd6, 1'b1, 1, 0);
        run_pass(11'h020, 11'h140, 11'h240, 11'd6, 1'b0, 0, T0 + 2);
        run_pass(11'h030, 11'h150, 11'h250, 11'd5, 1'b1, 1, T0 + 11);
        for (int i = 0; i < 8; i++) begin
            run_pass(11'($urandom), 11'($urandom), 11'($urandom),
                     11'($urandom_range(0, 12)), 1'($urandom), 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
